// File: rtl/borrow_select_subtractor_pipe.sv
// Two-stage borrow-select subtractor D = A - B - Bin with borrow/overflow/zero/negative flags.
// Latency 2 cycles, 1 op/cycle; stalls hold D and flags stable, in_ready drops once both stages are full.
module borrow_select_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int LOW_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int HIGH_W = WIDTH - LOW_W;

  logic [LOW_W:0]   low_d;
  logic [HIGH_W:0]  h0_d;
  logic [HIGH_W:0]  h1_d;

  logic             s1_valid_q;
  logic [LOW_W-1:0] s1_low_q;
  logic             s1_lb_q;
  logic [HIGH_W:0]  s1_h0_q;
  logic [HIGH_W:0]  s1_h1_q;
  logic             s1_amsb_q;
  logic             s1_bmsb_q;

  logic [HIGH_W:0]  hi_sel;
  logic [WIDTH-1:0] dif_d;
  logic             bout_d;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;

  logic             s1_load;
  logic             s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Each slice carries one extra MSB that ends up holding its borrow.
  always_comb begin
    low_d = {1'b0, A[LOW_W-1:0]} - {1'b0, B[LOW_W-1:0]} - {{LOW_W{1'b0}}, Bin};
    h0_d  = {1'b0, A[WIDTH-1:LOW_W]} - {1'b0, B[WIDTH-1:LOW_W]};
    h1_d  = {1'b0, A[WIDTH-1:LOW_W]} - {1'b0, B[WIDTH-1:LOW_W]} - {{HIGH_W{1'b0}}, 1'b1};
  end

  always_comb begin
    hi_sel = s1_lb_q ? s1_h1_q : s1_h0_q;
    dif_d  = {hi_sel[HIGH_W-1:0], s1_low_q};
    bout_d = hi_sel[HIGH_W];
    zero_d = (dif_d == '0);
    neg_d  = dif_d[WIDTH-1];
    ovf_d  = (s1_amsb_q != s1_bmsb_q) && (dif_d[WIDTH-1] != s1_amsb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_low_q   <= '0;
      s1_lb_q    <= 1'b0;
      s1_h0_q    <= '0;
      s1_h1_q    <= '0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      s1_low_q   <= low_d[LOW_W-1:0];
      s1_lb_q    <= low_d[LOW_W];
      s1_h0_q    <= h0_d;
      s1_h1_q    <= h1_d;
      s1_amsb_q  <= A[WIDTH-1];
      s1_bmsb_q  <= B[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      D         <= dif_d;
      Bout      <= bout_d;
      ovf       <= ovf_d;
      zero      <= zero_d;
      neg       <= neg_d;
    end
  end

endmodule
